// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit common-anode scanner with guard interval, blanking and frame-synchronous double buffer
module display_scan_ctrl #(
    parameter int PRESCALE = 50000,
    parameter int GUARD    = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank,
    input  logic        lzb,
    input  logic        load,
    output logic [3:0]  nib,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_done,
    output logic        busy_pending
);
    typedef enum logic {S_GUARD, S_DRIVE} state_t;

    state_t      st_q, st_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] act_q, act_d, pend_q, pend_d;
    logic        busy_q, busy_d, fd_q, fd_d, lzb_q, lzb_d;
    logic        tick, boundary, lz_dark, lit;
    logic [3:0]  zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= S_GUARD;
            cnt_q  <= '0;
            idx_q  <= '0;
            act_q  <= '0;
            pend_q <= '0;
            busy_q <= 1'b0;
            fd_q   <= 1'b0;
            lzb_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            act_q  <= act_d;
            pend_q <= pend_d;
            busy_q <= busy_d;
            fd_q   <= fd_d;
            lzb_q  <= lzb_d;
        end
    end

    // buffers are packed as {blank, dp_in, digits}
    always_comb begin
        tick     = cnt_q == 16'(PRESCALE - 1);
        boundary = tick && idx_q == 2'd3;
        cnt_d    = tick ? '0 : cnt_q + 16'd1;
        idx_d    = tick ? idx_q + 2'd1 : idx_q;
        fd_d     = boundary;
        lzb_d    = lzb;
        act_d    = act_q;
        pend_d   = pend_q;
        busy_d   = busy_q;
        if (boundary) begin
            act_d  = load ? {blank, dp_in, digits} : (busy_q ? pend_q : act_q);
            busy_d = 1'b0;
        end else if (load) begin
            pend_d = {blank, dp_in, digits};
            busy_d = 1'b1;
        end
        st_d = (st_q == S_GUARD) ? ((cnt_q == 16'(GUARD - 1)) ? S_DRIVE : S_GUARD)
                                 : (tick ? S_GUARD : S_DRIVE);
    end

    always_comb begin
        for (int i = 0; i < 4; i++) zero[i] = act_q[4*i +: 4] == 4'd0;
        lz_dark = lzb_q && ((idx_q == 2'd1) ? &zero[3:1] :
                            (idx_q == 2'd2) ? &zero[3:2] :
                            (idx_q == 2'd3) ? zero[3] : 1'b0);
        lit          = st_q == S_DRIVE && !act_q[{3'b101, idx_q}] && !lz_dark;
        nib          = act_q[{idx_q, 2'b00} +: 4];
        an           = lit ? ~(4'b0001 << idx_q) : 4'b1111;
        dp           = lit ? ~act_q[{3'b100, idx_q}] : 1'b1;
        frame_done   = fd_q;
        busy_pending = busy_q;
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: table, directed and random checks against a time-based display model
module tb_display_scan_ctrl;
    localparam int P  = 8;
    localparam int G  = 2;
    localparam int FR = 4 * P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dp_in = '0, blank = '0;
    logic        lzb = 1'b0, load = 1'b0;
    logic [3:0]  nib, an;
    logic        dp, frame_done, busy_pending;

    int          n_chk = 0, n_fail = 0;
    int          m_t = 0;
    logic [23:0] m_act = '0, m_pend = '0;
    logic        m_busy = 1'b0, m_lzb = 1'b0;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  dpi, blk;
        logic        lz;
        logic [15:0] e_nib, e_an;
        logic [3:0]  e_dp;
    } vec_t;
    vec_t vt[6];

    display_scan_ctrl #(.PRESCALE(P), .GUARD(G)) dut (
        .clk(clk), .rst_n(rst_n), .digits(digits), .dp_in(dp_in), .blank(blank),
        .lzb(lzb), .load(load), .nib(nib), .an(an), .dp(dp),
        .frame_done(frame_done), .busy_pending(busy_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%h expected=%h", nm, m_t, got, exp);
        end
    endtask

    // expected outputs follow from elapsed cycles: slot = t/P mod 4, phase = t mod P
    task automatic check_all();
        int slot, ph;
        logic dark, lit;
        slot = (m_t / P) % 4;
        ph   = m_t % P;
        dark = m_act[20 + slot] || (m_lzb && slot > 0 && (m_act[15:0] >> (4 * slot)) == 16'd0);
        lit  = ph >= G && !dark;
        chk("nib", {12'd0, nib}, (m_act[15:0] >> (4 * slot)) & 16'hF);
        chk("an", {12'd0, an}, lit ? {12'd0, ~(4'b0001 << slot)} : 16'hF);
        chk("dp", {15'd0, dp}, lit ? {15'd0, ~m_act[16 + slot]} : 16'd1);
        chk("frame_done", {15'd0, frame_done}, (m_t > 0 && m_t % FR == 0) ? 16'd1 : 16'd0);
        chk("busy_pending", {15'd0, busy_pending}, {15'd0, m_busy});
    endtask

    task automatic model_edge();
        if (!rst_n) return;
        if (m_t % FR == FR - 1) begin
            if (load) m_act = {blank, dp_in, digits};
            else if (m_busy) m_act = m_pend;
            m_busy = 1'b0;
        end else if (load) begin
            m_pend = {blank, dp_in, digits};
            m_busy = 1'b1;
        end
        m_lzb = lzb;
        m_t++;
    endtask

    task automatic tick_cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic goto(input int ph);
        do tick_cycle(); while (m_t % FR != ph);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dpi, input logic [3:0] blk, input logic lz);
        digits = d; dp_in = dpi; blank = blk; lzb = lz; load = 1'b1;
        tick_cycle();
        load = 1'b0;
    endtask

    initial begin
        vt[0] = '{16'h1A3F, 4'b0100, 4'b0000, 1'b0, 16'h1A3F, 16'h7BDE, 4'b1011};
        vt[1] = '{16'h0040, 4'b0000, 4'b0000, 1'b1, 16'h0040, 16'hFFDE, 4'b1111};
        vt[2] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 16'h0000, 16'hFFFE, 4'b1111};
        vt[3] = '{16'h1234, 4'b0010, 4'b0010, 1'b0, 16'h1234, 16'h7BFE, 4'b1111};
        vt[4] = '{16'hBEEF, 4'b1111, 4'b0000, 1'b1, 16'hBEEF, 16'h7BDE, 4'b0000};
        vt[5] = '{16'h0A00, 4'b0000, 4'b0000, 1'b1, 16'h0A00, 16'hFBDE, 4'b1111};

        @(negedge clk);
        check_all();
        repeat (3) tick_cycle();
        rst_n = 1'b1;
        goto(0);
        goto(0);

        foreach (vt[k]) begin
            goto(10);
            do_load(vt[k].d, vt[k].dpi, vt[k].blk, vt[k].lz);
            chk("tbl_busy", {15'd0, busy_pending}, 16'd1);
            goto(0);
            for (int s = 0; s < 4; s++) begin
                goto(s * P + P - 1);
                chk("tbl_nib", {12'd0, nib}, {12'd0, vt[k].e_nib[4*s +: 4]});
                chk("tbl_an", {12'd0, an}, {12'd0, vt[k].e_an[4*s +: 4]});
                chk("tbl_dp", {15'd0, dp}, {15'd0, vt[k].e_dp[s]});
            end
        end

        goto(FR - 1);
        do_load(16'h5678, 4'b0000, 4'b0000, 1'b0);
        chk("bnd_busy", {15'd0, busy_pending}, 16'd0);
        chk("bnd_nib0", {12'd0, nib}, 16'h8);
        goto(P + P - 1);
        chk("bnd_nib1", {12'd0, nib}, 16'h7);

        goto(5);
        do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
        chk("two_busy", {15'd0, busy_pending}, 16'd1);
        goto(20);
        do_load(16'h2222, 4'b0000, 4'b0000, 1'b0);
        goto(0);
        for (int s = 0; s < 4; s++) begin
            goto(s * P + P - 1);
            chk("two_nib", {12'd0, nib}, 16'h2);
        end

        goto(3);
        do_load(16'h9ABC, 4'b1111, 4'b0000, 1'b0);
        goto(2 * P + 4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_an", {12'd0, an}, 16'hF);
        chk("arst_busy", {15'd0, busy_pending}, 16'd0);
        m_t = 0; m_act = '0; m_pend = '0; m_busy = 1'b0; m_lzb = 1'b0;
        repeat (2) tick_cycle();
        rst_n = 1'b1;
        goto(G);
        chk("post_rst_an", {12'd0, an}, 16'hE);
        chk("post_rst_nib", {12'd0, nib}, 16'h0);
        goto(0);

        for (int c = 0; c < 400; c++) begin
            digits = 16'($urandom);
            dp_in  = 4'($urandom);
            blank  = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
            load   = $urandom_range(7) == 0;
            if (load) lzb = 1'($urandom);
            tick_cycle();
        end
        load = 1'b0;
        goto(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexes one shared hex-to-7-segment decoder across a 4-digit common-anode display.
- Each cycle it selects one nibble to drive onto the decoder inputs, asserts the matching active-low anode, and drives the decimal point.
- It double-buffers the displayed value so updates take effect only at frame boundaries.
- It applies per-digit blanking, optional leading-zero blanking, and a guard (all-anodes-off) interval at the start of each digit slot to prevent ghosting.

Parameters:
- PRESCALE, 50000: clock cycles per digit slot (1 kHz digit rate at 50 MHz); legal range 4..65535.
- GUARD, 500: cycles at the start of each slot with all anodes off; legal range 1..PRESCALE-2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- digits  input  16  four hex nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- dp_in  input  4  decimal point request per digit, 1 = lit.
- blank  input  4  per-digit force-blank, 1 = digit dark.
- lzb  input  1  leading-zero blank enable; static between loads.
- load  input  1  one-cycle strobe that captures digits/dp_in/blank into the pending buffer.
- nib  output  4  nibble to decoder inputs n3..n0 (nib[3] = n3).
- an  output  4  anode enables, active-low, an[i] selects digit i.
- dp  output  1  decimal point segment, active-low.
- frame_done  output  1  one-cycle pulse when digit 3's slot ends.
- busy_pending  output  1  high while a loaded value waits for the frame boundary.

Behaviour:
- Reset (asynchronous, while rst_n=0), all registers cleared:
  - an=4'b1111, dp=1, nib=0, frame_done=0, busy_pending=0.
  - Slot counter=0, digit index=0, active and pending buffers=0.
- Reset release:
  - Scanning starts at digit 0, slot counter 0.
  - Reset mid-frame discards the pending load.
- Outputs are decoded from registered state only; there is no combinational path from any input to any output.
- Slot counter:
  - Counts 0..PRESCALE-1, then wraps to 0.
  - tick = (count == PRESCALE-1).
  - On tick the index advances 0→1→2→3→0.
- State per slot:
  - GUARD state while count < GUARD: an=4'b1111, dp=1. nib already shows the current digit's nibble so the decoder settles.
  - DRIVE state for count >= GUARD: an = ~(4'b0001 << index), unless the digit is dark.
- Digit dark when any of:
  - active blank[index]=1, or
  - lzb=1 and index≥1 and active nibbles index..3 are all zero.
  - Digit 0 is never leading-zero blanked.
  - A dark digit keeps an=4'b1111 and dp=1 for the whole slot.
- dp during DRIVE of a lit digit = ~active dp_in[index].
- Frame boundary = tick with index==3.
  - frame_done=1 for exactly the cycle after the boundary edge, i.e. coincident with index returning to 0.
- Load/double-buffer:
  - load=1 captures inputs into pending and sets busy_pending.
  - At the frame boundary, if busy_pending=1: active←pending, busy_pending←0.
  - load asserted in the boundary cycle itself: the inputs go directly into active and busy_pending stays 0.
  - Multiple loads within one frame: the last one wins.
  - The active buffer never changes mid-frame.
- Timing:
  - One frame = 4*PRESCALE cycles.
  - Data loaded at cycle t becomes visible at the first digit-0 slot after the next boundary.

Test Plan:
1. Reset/idle (PRESCALE=8, GUARD=2): hold rst_n=0 → an=1111, dp=1, nib=0. Release, no load → each slot shows nib=0; digits 0–3 lit in turn (an=1110,1101,1011,0111) for cycles 2..7 of each slot; frame_done pulses every 32 cycles.
2. Load 16'h1A3F, dp_in=4'b0100, blank=0 mid-frame → no change until the boundary, busy_pending=1. Next frame gives nib=F,3,A,1 across slots 0..3, with dp=0 only during the DRIVE of digit 2.
3. Load in the exact boundary cycle → value appears in the same following frame and busy_pending never rises. Two loads (16'h1111 then 16'h2222) within one frame → only 16'h2222 is displayed.
4. lzb=1, load 16'h0040 → digits 3 and 2 dark (an=1111 for their whole slots); digits 1 (nib=4) and 0 (nib=0) lit. Load 16'h0000 → only digit 0 lit, showing 0.
5. blank=4'b0010 with dp_in=4'b0010 → digit 1 slot shows an=1111 and dp=1 for all 8 cycles.
6. Assert rst_n=0 mid-slot of digit 2 with a pending load → an=1111 immediately (asynchronously). After release, scanning restarts at digit 0 with the display showing 0 and busy_pending=0.
